// File: rtl/axi_slave_pkg.sv
// Shared constants and types for the AXI3 RAM slave: burst and response codes,
// FSM state encoding and the beat-counter width.
package axi_slave_pkg;

   localparam int unsigned BEAT_W = 4;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WD   = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/bytewise_ram.sv
// Single-port-pair word RAM: 4 independent byte-lane write enables and a
// registered read port whose output only changes when re_i is high.
module bytewise_ram #(
   parameter int unsigned ADDR_W    = 12,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [3:0]        wstrb_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [31:0]       rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [31:0] FILL  = {32{INIT_ZERO ? 1'b0 : 1'bx}};

   // Contents are never touched by rst; the fill value only matters in simulation.
   logic [31:0] mem_q [DEPTH] = '{default: FILL};
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a byte-writable word RAM; serves one read or write burst
// at a time through a single IDLE/RD/WD/WB state machine.
module axi_ram_slave
   import axi_slave_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic [1:0]  arlock,
   input  logic [3:0]  arcache,
   input  logic [2:0]  arprot,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic [1:0]  awlock,
   input  logic [3:0]  awcache,
   input  logic [2:0]  awprot,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   state_e              state_q, state_d;
   logic [3:0]          id_q, id_d;
   logic [ADDR_W-1:0]   idx_q, idx_d, idx_next;
   beat_t               beat_q, beat_d, len_q, len_d;
   logic [1:0]          burst_q, burst_d;
   logic                err_q, err_d;

   logic                ar_hs, aw_hs, r_hs, w_hs, b_hs;
   logic                last_beat, w_end;
   logic [ADDR_W-1:0]   ar_idx, aw_idx;
   logic                ram_re;
   logic [ADDR_W-1:0]   ram_raddr;
   logic                unused_c;

   assign ar_idx    = araddr[ADDR_W+1:2];
   assign aw_idx    = awaddr[ADDR_W+1:2];
   assign ar_hs     = arvalid & arready;
   assign aw_hs     = awvalid & awready;
   assign r_hs      = rvalid & rready;
   assign w_hs      = wvalid & wready;
   assign b_hs      = bvalid & bready;
   assign last_beat = (beat_q == len_q);
   assign w_end     = wlast | last_beat;
   // Anything that is not FIXED walks the RAM linearly and wraps at the top.
   assign idx_next  = (burst_q == BURST_FIXED) ? idx_q : idx_q + ADDR_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (aw_hs)      state_d = ST_WD;
            else if (ar_hs) state_d = ST_RD;
         end
         ST_RD:   if (r_hs && last_beat) state_d = ST_IDLE;
         ST_WD:   if (w_hs && w_end)     state_d = ST_WB;
         ST_WB:   if (b_hs)              state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Write wins a same-cycle tie; ready is forced low while rst is held.
   always_comb begin
      arready = 1'b0;
      awready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bresp   = RESP_OKAY;
      case (state_q)
         ST_IDLE: begin
            awready = ~rst;
            arready = ~rst & ~awvalid;
         end
         ST_RD: begin
            rvalid = 1'b1;
            rlast  = last_beat;
         end
         ST_WD:   wready = 1'b1;
         ST_WB: begin
            bvalid = 1'b1;
            bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
         end
         default: ;
      endcase
   end

   always_comb begin
      id_d      = id_q;
      idx_d     = idx_q;
      beat_d    = beat_q;
      len_d     = len_q;
      burst_d   = burst_q;
      err_d     = err_q;
      ram_re    = 1'b0;
      ram_raddr = idx_next;
      if (aw_hs) begin
         id_d    = awid;
         idx_d   = aw_idx;
         len_d   = awlen[BEAT_W-1:0];
         burst_d = awburst;
         beat_d  = '0;
      end else if (ar_hs) begin
         id_d      = arid;
         idx_d     = ar_idx;
         len_d     = arlen[BEAT_W-1:0];
         burst_d   = arburst;
         beat_d    = '0;
         ram_re    = 1'b1;
         ram_raddr = ar_idx;
      end
      // Prefetch the next word only when the current beat is consumed, so rdata holds under stall.
      if (r_hs && !last_beat) begin
         beat_d = beat_q + BEAT_W'(1);
         idx_d  = idx_next;
         ram_re = 1'b1;
      end
      if (w_hs) begin
         beat_d = beat_q + BEAT_W'(1);
         idx_d  = idx_next;
         if (w_end) err_d = wlast ^ last_beat;
      end
      if (b_hs) err_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_q    <= '0;
         idx_q   <= '0;
         beat_q  <= '0;
         len_q   <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         id_q    <= id_d;
         idx_q   <= idx_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         err_q   <= err_d;
      end
   end

   assign rid   = id_q;
   assign bid   = id_q;
   assign rresp = RESP_OKAY;

   bytewise_ram #(
      .ADDR_W    (ADDR_W),
      .INIT_ZERO (INIT_ZERO)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (w_hs),
      .wstrb_i (wstrb),
      .waddr_i (idx_q),
      .wdata_i (wdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (rdata)
   );

   // Sideband fields and unused address/length bits are accepted but have no effect.
   assign unused_c = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                       wid, arlen, awlen, araddr, awaddr};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomized self-checking bench for axi_ram_slave against a flat word-array
// memory model that applies AXI burst addressing and strobe rules directly.
module tb_axi_ram_slave;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam logic [1:0]  FIXED  = 2'b00;
   localparam logic [1:0]  INCR   = 2'b01;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   always #5 clk = ~clk;

   axi_ram_slave #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   logic [31:0] model_mem [DEPTH];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] last_rd;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // Word index of beat k: byte address / 4, aliased into the RAM, frozen for FIXED.
   function automatic int unsigned beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int k);
      int unsigned base;
      base = (addr >> 2) % DEPTH;
      return (burst == FIXED) ? base : (base + k) % DEPTH;
   endfunction

   function automatic logic sig_of(input int sel);
      case (sel)
         0:       return arready;
         1:       return awready;
         2:       return wready;
         default: return rvalid;
      endcase
   endfunction

   task automatic wait_hi(input int sel, input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sig_of(sel)) break;
      end
      check(tag, 32'(sig_of(sel)), 1);
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      @(posedge clk); #1;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
      wait_hi(1, "awready");
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic send_w_b(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int wlast_at, input int stall_b);
      int   k = 0;
      logic done = 1'b0;
      logic err = 1'b0;
      while (!done) begin
         if ($urandom_range(3) == 0) begin
            wvalid = 1'b0;
            @(posedge clk); #1;
         end
         wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; wlast = (k == wlast_at);
         wait_hi(2, "wready");
         @(posedge clk); #1;
         for (int b = 0; b < 4; b++)
            if (ws[k][b]) model_mem[beat_idx(addr, burst, k)][8*b +: 8] = wd[k][8*b +: 8];
         done = (k == wlast_at) || (k == len);
         err  = (k == wlast_at) != (k == len);
         k++;
      end
      wvalid = 1'b0; wlast = 1'b0;
      @(negedge clk);
      check("wready_after_burst", 32'(wready), 0);
      check("bvalid", 32'(bvalid), 1);
      check("bid", 32'(bid), 32'(id));
      check("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
      for (int s = 0; s < stall_b; s++) begin
         @(negedge clk);
         check("bvalid_hold", 32'(bvalid), 1);
      end
      @(posedge clk); #1;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("bvalid_drop", 32'(bvalid), 0);
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst);
      arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
      wait_hi(0, "arready");
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   // stall_mode: 0 never, 1 before every beat, 2 at random.
   task automatic recv_r(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int stall_mode);
      logic [31:0] exp;
      for (int k = 0; k <= len; k++) begin
         exp = model_mem[beat_idx(addr, burst, k)];
         if (stall_mode == 1 || (stall_mode == 2 && $urandom_range(1) == 1)) begin
            rready = 1'b0;
            @(negedge clk);
            check("r_hold_valid", 32'(rvalid), 1);
            check("r_hold_data", rdata, exp);
            check("r_hold_last", 32'(rlast), 32'(k == len));
            @(posedge clk); #1;
         end
         rready = 1'b1;
         @(negedge clk);
         check("rvalid", 32'(rvalid), 1);
         check("rdata", rdata, exp);
         check("rlast", 32'(rlast), 32'(k == len));
         check("rid", 32'(rid), 32'(id));
         check("rresp", 32'(rresp), 0);
         last_rd = rdata;
         @(posedge clk); #1;
         rready = 1'b0;
      end
      @(negedge clk);
      check("rvalid_drop", 32'(rvalid), 0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_mode);
      @(posedge clk); #1;
      send_ar(id, addr, len, burst);
      recv_r(id, addr, int'(len[3:0]), burst, stall_mode);
   endtask

   task automatic write_word(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
      wd[0] = data; ws[0] = strb;
      send_aw(id, addr, 8'd0, INCR);
      send_w_b(id, addr, 0, INCR, 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      rst = 1'b1;
      {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot} = '0;
      {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot} = '0;
      {wid, wdata, wstrb, wlast, wvalid, rready, bready, awvalid} = '0;
      arvalid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arready", 32'(arready), 0);
      check("rst_awready", 32'(awready), 0);
      check("rst_rvalid", 32'(rvalid), 0);
      check("rst_wready", 32'(wready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_rdata", rdata, 0);
      check("rst_rlast", 32'(rlast), 0);
      check("rst_rid_bid", 32'({rid, bid}), 0);
      check("rst_resp", 32'({rresp, bresp}), 0);
      @(posedge clk); #1;
      arvalid = 1'b0; rst = 1'b0;

      // single write then read
      write_word(4'h3, 32'h10, 32'hDEADBEEF, 4'hF);
      do_read(4'h5, 32'h10, 8'd0, INCR, 0);
      check("single_value", last_rd, 32'hDEADBEEF);

      // 4-beat INCR, read back with rready stalling before every beat
      for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
      send_aw(4'h1, 32'h100, 8'd3, INCR);
      send_w_b(4'h1, 32'h100, 3, INCR, 3, 2);
      do_read(4'h2, 32'h100, 8'd3, INCR, 1);
      check("incr_final", last_rd, 32'd4);

      // byte strobes
      write_word(4'h4, 32'h200, 32'h11223344, 4'hF);
      write_word(4'h4, 32'h200, 32'h000000AA, 4'h1);
      write_word(4'h4, 32'h200, 32'hBB000000, 4'h8);
      do_read(4'h4, 32'h200, 8'd0, INCR, 0);
      check("strobe_merge", last_rd, 32'hBB2233AA);

      // AR/AW tie: write served first, AR stays pending; FIXED write keeps last beat
      @(posedge clk); #1;
      arid = 4'h6; araddr = 32'h20; arlen = 8'd0; arburst = FIXED; arvalid = 1'b1;
      awid = 4'h7; awaddr = 32'h20; awlen = 8'd2; awburst = FIXED; awvalid = 1'b1;
      @(negedge clk);
      check("tie_awready", 32'(awready), 1);
      check("tie_arready", 32'(arready), 0);
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      check("ar_blocked_in_wd", 32'(arready), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 5); ws[i] = 4'hF; end
      send_w_b(4'h7, 32'h20, 2, FIXED, 2, 1);
      check("pending_ar_ready", 32'(arready), 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      recv_r(4'h6, 32'h20, 0, FIXED, 0);
      check("fixed_value", last_rd, 32'd7);

      // INCR wraps from the top word back to word 0
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      send_aw(4'h2, 32'h3FF8, 8'd3, INCR);
      send_w_b(4'h2, 32'h3FF8, 3, INCR, 3, 0);
      do_read(4'h2, 32'h3FF8, 8'd3, INCR, 0);
      do_read(4'h2, 32'h0, 8'd1, INCR, 0);

      // early wlast and missing wlast both end in SLVERR
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      send_aw(4'h8, 32'h180, 8'd3, INCR);
      send_w_b(4'h8, 32'h180, 3, INCR, 2, 0);
      do_read(4'h8, 32'h180, 8'd3, INCR, 0);
      send_aw(4'h9, 32'h1C0, 8'd1, INCR);
      send_w_b(4'h9, 32'h1C0, 1, INCR, -1, 0);
      do_read(4'h9, 32'h1C0, 8'd2, INCR, 0);

      // reset in the middle of a read burst
      @(posedge clk); #1;
      send_ar(4'hA, 32'h100, 8'd3, INCR);
      rready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("pre_rst_rdata", rdata, model_mem[beat_idx(32'h100, INCR, k)]);
         @(posedge clk); #1;
      end
      rready = 1'b0; rst = 1'b1;
      #1;
      check("midrst_rvalid", 32'(rvalid), 0);
      check("midrst_readies", 32'({arready, awready}), 0);
      check("midrst_rdata", rdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 32'({arready, awready}), 32'h3);
      do_read(4'hB, 32'h100, 8'd3, INCR, 2);

      // randomized mix of reads and writes over a small aliased window
      for (int t = 0; t < 60; t++) begin
         logic [31:0] addr;
         logic [1:0]  burst;
         int          len, wl;
         addr  = 32'h400 + (32'($urandom_range(31)) << 2) + 32'($urandom_range(3));
         if ($urandom_range(1) == 1) addr = addr | ($urandom & 32'hFFFF_C000);
         burst = 2'($urandom_range(3));
         len   = int'($urandom_range(15));
         if ($urandom_range(1) == 1) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            wl = len;
            if ($urandom_range(4) == 0) begin
               wl = int'($urandom_range(16));
               if (wl == 16) wl = -1;
            end
            send_aw(4'($urandom), addr, {4'($urandom), 4'(len)}, burst);
            send_w_b(awid, addr, len, burst, wl, int'($urandom_range(2)));
         end else begin
            do_read(4'($urandom), addr, {4'($urandom), 4'(len)}, burst, 2);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
